// File: rtl/regfile_8x16.sv
// regfile_8x16: eight 16-bit registers with one write port, two combinational
// read ports and a per-register busy scoreboard for tracking pending writebacks.
// Ports: clk/rst (async active-high); we/waddr/wdata write port;
//        ra_addr/rb_addr -> ra_data/rb_data, ra_busy/rb_busy read ports;
//        lock_en/lock_addr set a busy bit; busy exposes the full scoreboard.
module regfile_8x16 #(
  parameter bit          BYPASS    = 1'b1,
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [2:0]  ra_addr,
  input  logic [2:0]  rb_addr,
  input  logic        lock_en,
  input  logic [2:0]  lock_addr,
  output logic [15:0] ra_data,
  output logic [15:0] rb_data,
  output logic        ra_busy,
  output logic        rb_busy,
  output logic [7:0]  busy
);

  logic [15:0] regs_q [8];
  logic [15:0] regs_d [8];
  logic [7:0]  busy_q;
  logic [7:0]  busy_d;

  logic ra_fwd;
  logic rb_fwd;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (we) begin
      regs_d[waddr] = wdata;
      busy_d[waddr] = 1'b0;
    end
    // Lock is applied after the write clear so a same-index lock wins.
    if (lock_en) begin
      busy_d[lock_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= RESET_VAL;
      end
      busy_q <= 8'h00;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // A write landing this cycle satisfies any pending lock on that register,
  // so a forwarded read is reported as not busy.
  assign ra_fwd = BYPASS && we && (waddr == ra_addr);
  assign rb_fwd = BYPASS && we && (waddr == rb_addr);

  assign ra_data = ra_fwd ? wdata : regs_q[ra_addr];
  assign rb_data = rb_fwd ? wdata : regs_q[rb_addr];
  assign ra_busy = busy_q[ra_addr] & ~ra_fwd;
  assign rb_busy = busy_q[rb_addr] & ~rb_fwd;
  assign busy    = busy_q;

endmodule

// File: doc/regfile_8x16.md
REGFILE_8X16 -- requirements
Module: regfile_8x16

Interface
REQ-001 Parameter BYPASS, default 1: when 1, same-cycle write data forwards to the read ports; when 0, reads return stored contents only.
REQ-002 Parameter RESET_VAL, default 16'h0000: value loaded into every register on reset.
REQ-003 clk  input  1  single clock for all state; rising-edge triggered.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 we  input  1  write enable for the write port.
REQ-006 waddr  input  3  write register index R0..R7.
REQ-007 wdata  input  16  write data.
REQ-008 ra_addr  input  3  read port A index.
REQ-009 rb_addr  input  3  read port B index.
REQ-010 lock_en  input  1  mark register lock_addr busy (pending writeback).
REQ-011 lock_addr  input  3  register index to lock.
REQ-012 ra_data  output  16  port A read data; feeds the downstream 8:1 operand mux.
REQ-013 rb_data  output  16  port B read data.
REQ-014 ra_busy  output  1  port A register has a pending write.
REQ-015 rb_busy  output  1  port B register has a pending write.
REQ-016 busy  output  8  scoreboard vector; bit i is set while Ri is locked.

Function
REQ-017 Storage SHALL be eight 16-bit registers R0..R7, all writable; R0 is not hardwired.
REQ-018 When we=1, wdata SHALL be written to R[waddr] on the rising clk edge; the write is visible on the stored value in the next cycle.
REQ-019 ra_data and rb_data SHALL be combinational reads of R[ra_addr] and R[rb_addr], with zero-cycle latency.
REQ-020 With BYPASS=1, if we=1 and waddr equals ra_addr, ra_data SHALL equal wdata in that cycle; the same rule applies to port B.
REQ-021 With BYPASS=0, ra_data and rb_data SHALL always reflect the stored values only.
REQ-022 Both ports SHALL read the same address simultaneously without conflict.
REQ-023 Scoreboard: on a clk edge with lock_en=1, busy[lock_addr] SHALL be set to 1.
REQ-024 Scoreboard: on a clk edge with we=1, busy[waddr] SHALL be cleared to 0, unless the lock rule sets it in the same edge.
REQ-025 If lock_en=1 and we=1 target the same index in the same cycle, the register SHALL take wdata and busy SHALL end set (the new lock wins).
REQ-026 If lock_en=1 and we=1 target different indices, both updates SHALL occur independently in the same edge.
REQ-027 Locking an already-busy register SHALL leave it busy; a write to a non-busy register SHALL leave it not busy.
REQ-028 ra_busy SHALL equal busy[ra_addr] AND NOT (BYPASS and we and waddr==ra_addr); rb_busy is defined the same way for port B.
REQ-029 Writes SHALL be accepted regardless of busy state; the block does not stall.

Reset
REQ-030 While rst=1, all registers SHALL hold RESET_VAL and busy SHALL be 8'h00, independent of clk.
REQ-031 Assertion of rst mid-operation SHALL immediately discard pending locks and stored data; a write coincident with rst SHALL be lost.
REQ-032 After rst deasserts, the first rising edge SHALL perform normal writes and locks.

Verification
REQ-033 Reset then read all eight indices on both ports -> all 16'h0000, busy=8'h00.
REQ-034 Write R3=16'hBEEF, next cycle ra_addr=3, rb_addr=3 -> both ports 16'hBEEF; same-cycle read with BYPASS=1 -> 16'hBEEF, with BYPASS=0 -> old value 16'h0000.
REQ-035 lock R5; ra_addr=5 -> ra_busy=1, busy=8'h20; write R5=16'h1234 -> ra_busy=0 in the write cycle (BYPASS=1), busy=8'h00 next cycle, ra_data=16'h1234.
REQ-036 Same-cycle lock R2 and write R2=16'h00AA -> R2=16'h00AA, busy[2]=1; lock R1 with write R6 -> busy[1]=1, busy[6]=0.
REQ-037 Lock R0, R7, and write R4=16'hFFFF, then pulse rst asynchronously between edges -> immediately busy=8'h00, R4=16'h0000.
